// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit: iterative multiply/divide unit with HI/LO registers for the EX stage.
// Radix-2 shift-add multiply (multu) and restoring divide (divu), one bit per cycle over
// WIDTH cycles, plus direct HI/LO writes (mthi/mtlo). busy stalls the pipeline while an
// operation iterates. done pulses in the cycle where HI/LO first show the new result.
// Optional macro MULDIV_SIGNED_EN adds signed mult (24) and div (26). With this macro,
// operands are converted to magnitudes on entry, and the results are sign-corrected on
// the final iteration.
module muldiv_hilo_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_q,
    output logic [WIDTH-1:0] lo_q
);

    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_DIVU  = 6'd27;
    localparam logic [5:0] F_MTHI  = 6'd17;
    localparam logic [5:0] F_MTLO  = 6'd19;
`ifdef MULDIV_SIGNED_EN
    localparam logic [5:0] F_MULT  = 6'd24;
    localparam logic [5:0] F_DIV   = 6'd26;
`endif
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opa_q, opa_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic [WIDTH-1:0]     hi_d, lo_d;
`ifdef MULDIV_SIGNED_EN
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 a_neg, b_neg;
`endif

    logic                 accept;
    logic                 is_mul, is_div;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_diff;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   prod_final;
    logic [WIDTH-1:0]     quo_final, rem_final;

    assign busy = (state_q == MUL) || (state_q == DIV);
    assign done = (state_q == FIN);

    // Decode the request and form operand magnitudes; signed ops record which signs to restore
    always_comb begin
        accept = start && ((state_q == IDLE) || (state_q == FIN));
        is_mul = (funct == F_MULTU);
        is_div = (funct == F_DIVU);
        a_mag  = a;
        b_mag  = b;
`ifdef MULDIV_SIGNED_EN
        is_mul = is_mul || (funct == F_MULT);
        is_div = is_div || (funct == F_DIV);
        a_neg  = ((funct == F_MULT) || (funct == F_DIV)) && a[WIDTH-1];
        b_neg  = ((funct == F_MULT) || (funct == F_DIV)) && b[WIDTH-1];
        if (a_neg) a_mag = -a;
        if (b_neg) b_mag = -b;
`endif
    end

    // One iteration of each datapath: shift-add multiply step and restoring divide step
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (opb_q[0] ? {1'b0, opa_q} : {(WIDTH+1){1'b0}});
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opb_q});
        div_diff  = div_shift[WIDTH-1:0] - opb_q;
        div_next  = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
        prod_final = mul_next;
        quo_final  = div_next[WIDTH-1:0];
        rem_final  = div_next[2*WIDTH-1:WIDTH];
`ifdef MULDIV_SIGNED_EN
        if (neg_res_q) begin
            prod_final = -mul_next;
            quo_final  = -div_next[WIDTH-1:0];
        end
        if (neg_rem_q) rem_final = -div_next[2*WIDTH-1:WIDTH];
`endif
    end

    // Next-state logic: launch operations, iterate, and write HI/LO on the last iteration
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef MULDIV_SIGNED_EN
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
`endif
        case (state_q)
            MUL: begin
                acc_d = mul_next;
                opb_d = {1'b0, opb_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = FIN;
                    cnt_d   = '0;
                    hi_d    = prod_final[2*WIDTH-1:WIDTH];
                    lo_d    = prod_final[WIDTH-1:0];
                end
            end
            DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = FIN;
                    cnt_d   = '0;
                    hi_d    = rem_final;
                    lo_d    = quo_final;
                end
            end
            IDLE, FIN: begin
                state_d = IDLE;
                if (accept) begin
                    if (is_mul) begin
                        state_d = MUL;
                        cnt_d   = '0;
                        acc_d   = '0;
                        opa_d   = a_mag;
                        opb_d   = b_mag;
`ifdef MULDIV_SIGNED_EN
                        neg_res_d = a_neg ^ b_neg;
                        neg_rem_d = 1'b0;
`endif
                    end else if (is_div) begin
                        state_d = DIV;
                        cnt_d   = '0;
                        acc_d   = {{WIDTH{1'b0}}, a_mag};
                        opb_d   = b_mag;
`ifdef MULDIV_SIGNED_EN
                        neg_res_d = (a_neg ^ b_neg) && (b != '0);
                        neg_rem_d = a_neg;
`endif
                    end else if (funct == F_MTHI) begin
                        hi_d = a;
                    end else if (funct == F_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation and clears HI/LO
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef MULDIV_SIGNED_EN
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef MULDIV_SIGNED_EN
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Testbench for muldiv_hilo_unit. Stimulus pushes expected HI/LO results and done cycles
// into a queue. A monitor pops the queue and checks each done pulse against it.
// Honours MULDIV_SIGNED_EN the same way the design does.
module tb_muldiv_hilo_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [5:0]    funct;
    logic [W-1:0]  a, b;
    logic          busy, done;
    logic [W-1:0]  hi_q, lo_q;

    typedef struct {
        string        nm;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           dcyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fails = 0;

    muldiv_hilo_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .funct(funct), .a(a), .b(b),
        .busy(busy), .done(done), .hi_q(hi_q), .lo_q(lo_q)
    );

    // Free-running clock and cycle counter used to time done pulses
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("[TB] FAIL unexpected_done: got done=1 expected done=0 at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_output({e.nm, "_hi"}, hi_q, e.hi);
                check_output({e.nm, "_lo"}, lo_q, e.lo);
                check_output({e.nm, "_done_cycle"}, W'(cyc), W'(e.dcyc));
            end
        end
    end

    // Drive one request for a cycle, then check busy right after the accepting edge
    task automatic apply_stimulus(input logic [5:0] f, input logic [W-1:0] av, input logic [W-1:0] bv,
                                  input logic exp_busy, input string nm);
        start = 1'b1;
        funct = f;
        a     = av;
        b     = bv;
        @(negedge clk);
        start = 1'b0;
        check_output({nm, "_busy"}, W'(busy), W'(exp_busy));
    endtask

    // Issue a multiply/divide and queue its expected result
    task automatic apply_op(input string nm, input logic [5:0] f, input logic [W-1:0] av,
                            input logic [W-1:0] bv, input logic [W-1:0] eh, input logic [W-1:0] el);
        exp_t e;
        e.nm = nm; e.hi = eh; e.lo = el; e.dcyc = cyc + 1 + W;
        exp_q.push_back(e);
        apply_stimulus(f, av, bv, 1'b1, nm);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fails++;
            $display("[TB] FAIL drain_timeout: got %0d pending results expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no end of test expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence
    initial begin
        rst = 1'b1; start = 1'b0; funct = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_output("reset_busy", W'(busy), '0);
        check_output("reset_done", W'(done), '0);
        check_output("reset_hi", hi_q, '0);
        check_output("reset_lo", lo_q, '0);

        apply_op("divu_100_7", 6'd27, 32'd100, 32'd7, 32'd2, 32'd14);
        wait_drain();
        apply_op("multu_max_2", 6'd25, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);
        wait_drain();
        apply_op("multu_max_max", 6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        wait_drain();
        apply_op("divu_7_100", 6'd27, 32'd7, 32'd100, 32'd7, 32'd0);
        wait_drain();
        apply_op("divu_max_1", 6'd27, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF);
        wait_drain();

        apply_stimulus(6'd17, 32'h0000_1234, 32'd0, 1'b0, "mthi");
        check_output("mthi_hi", hi_q, 32'h0000_1234);
        apply_stimulus(6'd19, 32'h0000_ABCD, 32'd0, 1'b0, "mtlo");
        check_output("mtlo_lo", lo_q, 32'h0000_ABCD);
        check_output("mtlo_hi_kept", hi_q, 32'h0000_1234);
        apply_stimulus(6'd32, 32'h5555_5555, 32'd3, 1'b0, "bad_funct");
        check_output("bad_funct_hi", hi_q, 32'h0000_1234);
        check_output("bad_funct_lo", lo_q, 32'h0000_ABCD);

        apply_op("divu_by_zero", 6'd27, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
        apply_stimulus(6'd17, 32'd9, 32'd0, 1'b1, "mthi_while_busy");
        wait_drain();
        check_output("mthi_ignored_hi", hi_q, 32'd5);

        apply_op("b2b_multu", 6'd25, 32'd12345, 32'd678, 32'd0, 32'd8369910);
        wait_done();
        apply_op("b2b_divu", 6'd27, 32'hFFFF_FFFF, 32'd16, 32'd15, 32'h0FFF_FFFF);
        wait_drain();

`ifdef MULDIV_SIGNED_EN
        apply_op("div_neg7_2", 6'd26, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        wait_drain();
        apply_op("mult_neg3_5", 6'd24, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        wait_drain();
        apply_op("div_neg7_0", 6'd26, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        wait_drain();
`else
        apply_stimulus(6'd26, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_unsupported");
        check_output("div_unsupported_hi", hi_q, 32'd15);
        check_output("div_unsupported_lo", lo_q, 32'h0FFF_FFFF);
        apply_stimulus(6'd24, 32'hFFFF_FFFD, 32'd5, 1'b0, "mult_unsupported");
        check_output("mult_unsupported_lo", lo_q, 32'h0FFF_FFFF);
`endif

        apply_stimulus(6'd25, 32'd3, 32'd4, 1'b1, "abort_multu");
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output("abort_busy", W'(busy), '0);
        check_output("abort_done", W'(done), '0);
        check_output("abort_hi", hi_q, '0);
        check_output("abort_lo", lo_q, '0);
        repeat (45) @(negedge clk);
        check_output("abort_hi_after", hi_q, '0);

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fails++;
            $display("[TB] FAIL pending_results: got %0d expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
